// File: rtl/timer_nivel2_pkg.sv
// Shared types and digit limits for the level-2 M:SS countdown timer.
package timer_nivel2_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t UNITS_MAX = 4'd9;
    localparam bcd_digit_t TENS_MAX  = 4'd5;
    localparam bcd_digit_t MIN_MAX   = 4'd9;

    // Clamp an incoming digit to the digit's own upper limit.
    function automatic bcd_digit_t bcd_sat(input bcd_digit_t x, input bcd_digit_t max);
        return (x > max) ? max : x;
    endfunction

endpackage

// File: rtl/timer_digit.sv
// One BCD down-counter digit: saturating shift-load, decrement with borrow, wrap to max.
module timer_digit
    import timer_nivel2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  bcd_digit_t shift_in,
    input  logic       load,
    input  logic       dec,
    input  bcd_digit_t max,
    output bcd_digit_t value,
    output logic       borrow_out
);

    bcd_digit_t value_q;
    bcd_digit_t value_d;

    // Load wins over decrement; decrementing 0 wraps to max and borrows.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = bcd_sat(shift_in, max);
        end else if (dec) begin
            value_d = (value_q == '0) ? max : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign borrow_out = (value_q == '0) && dec;

endmodule

// File: rtl/timer_nivel2.sv
// M:SS countdown timer from three chained BCD digits with serial shift-load.
// Build option TIMER_NIVEL2_WRAP_EN: counting at 0:00 wraps to 9:59 instead of holding.
module timer_nivel2
    import timer_nivel2_pkg::*;
(
    input  logic       [DIGIT_W-1:0] data,
    input  logic                     clk,
    input  logic                     enable,
    input  logic                     loadn,
    input  logic                     clearn,
    output logic       [DIGIT_W-1:0] unidades,
    output logic       [DIGIT_W-1:0] dezenas,
    output logic       [DIGIT_W-1:0] minutos,
    output logic                     zero
);

    logic load;
    logic dec_units;
    logic borrow_units;
    logic borrow_tens;
    logic min_borrow_unused;

    assign load = ~loadn;

`ifdef TIMER_NIVEL2_WRAP_EN
    assign dec_units = enable && loadn;
`else
    // At 0:00 the chain is simply not stepped, so the value holds.
    assign dec_units = enable && loadn && !zero;
`endif

    timer_digit u_units (
        .clk        (clk),
        .rst        (clearn),
        .shift_in   (data),
        .load       (load),
        .dec        (dec_units),
        .max        (UNITS_MAX),
        .value      (unidades),
        .borrow_out (borrow_units)
    );

    timer_digit u_tens (
        .clk        (clk),
        .rst        (clearn),
        .shift_in   (unidades),
        .load       (load),
        .dec        (borrow_units),
        .max        (TENS_MAX),
        .value      (dezenas),
        .borrow_out (borrow_tens)
    );

    timer_digit u_min (
        .clk        (clk),
        .rst        (clearn),
        .shift_in   (dezenas),
        .load       (load),
        .dec        (borrow_tens),
        .max        (MIN_MAX),
        .value      (minutos),
        .borrow_out (min_borrow_unused)
    );

    assign zero = (unidades == '0) && (dezenas == '0) && (minutos == '0);

endmodule

// File: tb/tb_timer_nivel2.sv
// Directed bench for timer_nivel2; compares {minutos, dezenas, unidades, zero}.
module tb_timer_nivel2;

    logic       clk = 1'b0;
    logic       clearn;
    logic       enable;
    logic       loadn;
    logic [3:0] data;
    logic [3:0] unidades;
    logic [3:0] dezenas;
    logic [3:0] minutos;
    logic       zero;

    int n_cmp  = 0;
    int n_miss = 0;

    timer_nivel2 dut (
        .data     (data),
        .clk      (clk),
        .enable   (enable),
        .loadn    (loadn),
        .clearn   (clearn),
        .unidades (unidades),
        .dezenas  (dezenas),
        .minutos  (minutos),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic [3:0] m, input logic [3:0] t,
                                       input logic [3:0] u, input logic z);
        return {m, t, u, z};
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h:%0h%0h zero=%b, want %0h:%0h%0h zero=%b", tag,
                     got[12:9], got[8:5], got[4:1], got[0],
                     exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    // Advance n rising edges, ending 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic shift_digit(input logic [3:0] d);
        loadn = 1'b0;
        data  = d;
        tick(1);
        loadn = 1'b1;
    endtask

    function automatic logic [12:0] cur();
        return pk(minutos, dezenas, unidades, zero);
    endfunction

    initial begin
        clearn = 1'b1;
        enable = 1'b0;
        loadn  = 1'b1;
        data   = 4'd0;
        #2;
        check("reset", cur(), pk(4'd0, 4'd0, 4'd0, 1'b1));
        #11;
        clearn = 1'b0;

        // Load 2:00 one digit per edge
        shift_digit(4'd2);
        check("load_1st", cur(), pk(4'd0, 4'd0, 4'd2, 1'b0));
        shift_digit(4'd0);
        shift_digit(4'd0);
        check("load_200", cur(), pk(4'd2, 4'd0, 4'd0, 1'b0));

        // Countdown from 2:00
        enable = 1'b1;
        tick(1);
        check("cnt_e1", cur(), pk(4'd1, 4'd5, 4'd9, 1'b0));
        tick(59);
        check("cnt_e60", cur(), pk(4'd1, 4'd0, 4'd0, 1'b0));
        tick(1);
        check("cnt_e61", cur(), pk(4'd0, 4'd5, 4'd9, 1'b0));
        tick(58);
        check("cnt_e119", cur(), pk(4'd0, 4'd0, 4'd1, 1'b0));
        tick(1);
        check("cnt_e120", cur(), pk(4'd0, 4'd0, 4'd0, 1'b1));
        tick(1);
`ifdef TIMER_NIVEL2_WRAP_EN
        check("cnt_e121_wrap", cur(), pk(4'd9, 4'd5, 4'd9, 1'b0));
`else
        check("cnt_e121_hold", cur(), pk(4'd0, 4'd0, 4'd0, 1'b1));
`endif

        // Asynchronous clear mid-count, then nothing counts without a load
        enable = 1'b0;
        shift_digit(4'd2);
        shift_digit(4'd0);
        shift_digit(4'd0);
        enable = 1'b1;
        tick(5);
        check("cnt_155", cur(), pk(4'd1, 4'd5, 4'd5, 1'b0));
        #2;
        clearn = 1'b1;
        #1;
        check("async_clr", cur(), pk(4'd0, 4'd0, 4'd0, 1'b1));
        #1;
        clearn = 1'b0;
        enable = 1'b0;
        tick(3);
        check("post_clr_hold", cur(), pk(4'd0, 4'd0, 4'd0, 1'b1));

        // Saturation: 7 -> 0:07, 7 -> 0:57 (tens clamp), 12 -> 5:59 (units clamp)
        shift_digit(4'd7);
        shift_digit(4'd7);
        check("sat_tens", cur(), pk(4'd0, 4'd5, 4'd7, 1'b0));
        shift_digit(4'd12);
        check("sat_units", cur(), pk(4'd5, 4'd5, 4'd9, 1'b0));

        // Priority: load beats enable at 1:30
        shift_digit(4'd1);
        shift_digit(4'd3);
        shift_digit(4'd0);
        check("load_130", cur(), pk(4'd1, 4'd3, 4'd0, 1'b0));
        enable = 1'b1;
        shift_digit(4'd4);
        check("prio_shift", cur(), pk(4'd3, 4'd0, 4'd4, 1'b0));
        enable = 1'b0;
        tick(10);
        check("hold_10", cur(), pk(4'd3, 4'd0, 4'd4, 1'b0));
        enable = 1'b1;
        tick(5);
        check("tens_borrow", cur(), pk(4'd2, 4'd5, 4'd9, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
        $finish;
    end

endmodule
